i2c_slave_responder: RTL

Synthesizable I2C target (responder) for one bus of the I2CMB multi-bus controller. It holds a fixed 7-bit address and ACKs write bytes, delivering them on a strobed byte port. It serves read bytes from a request/data port. It sits on one `scl`/`sda` pair beside the iicmb master and acts as the RTL counterpart to the bench's behavioural slave, so the controller can be checked against real hardware in loopback and on FPGA.

---
 rtl/i2c_slave_responder.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_slave_responder.sv
// I2C target responder: fixed 7-bit address, ACKs every write byte, serves read bytes via tx_req/tx_data.
// Optional input glitch filter enabled by defining I2C_RESP_GLITCH_FILTER_EN.
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h22,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic [7:0] tx_data_i,
    output logic       tx_req_o,
    output logic       start_o,
    output logic       stop_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        RX,
        RX_ACK,
        TX,
        TX_ACK,
        IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_raw, sda_raw;
    logic                   scl_s, sda_s;
    logic                   scl_q, sda_q;

    // Bus idles high, so the synchronizers reset to 1 to avoid false edges.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end
    end

    assign scl_raw = scl_sync[SYNC_STAGES-1];
    assign sda_raw = sda_sync[SYNC_STAGES-1];

`ifdef I2C_RESP_GLITCH_FILTER_EN
    logic [1:0] scl_hist, sda_hist;
    logic       scl_held, sda_held;

    // Output follows the input only once the current and two previous samples agree.
    assign scl_s = (scl_raw == scl_hist[0] && scl_raw == scl_hist[1]) ? scl_raw : scl_held;
    assign sda_s = (sda_raw == sda_hist[0] && sda_raw == sda_hist[1]) ? sda_raw : sda_held;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_held <= 1'b1;
            sda_held <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_raw};
            sda_hist <= {sda_hist[0], sda_raw};
            scl_held <= scl_s;
            sda_held <= sda_s;
        end
    end
`else
    assign scl_s = scl_raw;
    assign sda_s = sda_raw;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_s;
            sda_q <= sda_s;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  = scl_s & ~scl_q;
    assign scl_fall  = ~scl_s & scl_q;
    assign start_det = scl_s & sda_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_q & sda_s;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       sda_q_o, sda_d_o;
    logic       busy_q, busy_d;
    logic       is_read_q, is_read_d;
    logic       ack_on_q, ack_on_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic [7:0] byte_in;

    assign byte_in = {shift_q[6:0], sda_s};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            sda_q_o    <= 1'b1;
            busy_q     <= 1'b0;
            is_read_q  <= 1'b0;
            ack_on_q   <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            sda_q_o    <= sda_d_o;
            busy_q     <= busy_d;
            is_read_q  <= is_read_d;
            ack_on_q   <= ack_on_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    // ack_on marks the second half of an ACK slot: driving low (ADDR_ACK/RX_ACK)
    // or a received master ACK awaiting the next data load (TX_ACK).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        sda_d_o    = sda_q_o;
        busy_d     = busy_q;
        is_read_d  = is_read_q;
        ack_on_d   = ack_on_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        start_d    = 1'b0;
        stop_d     = 1'b0;

        if (start_det) begin
            state_d  = ADDR;
            cnt_d    = 3'd0;
            shift_d  = 8'h00;
            sda_d_o  = 1'b1;
            ack_on_d = 1'b0;
            start_d  = 1'b1;
        end else if (stop_det) begin
            state_d  = IDLE;
            cnt_d    = 3'd0;
            sda_d_o  = 1'b1;
            busy_d   = 1'b0;
            ack_on_d = 1'b0;
            stop_d   = 1'b1;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (byte_in[7:1] == SLAVE_ADDR) begin
                                state_d   = ADDR_ACK;
                                is_read_d = byte_in[0];
                            end else begin
                                state_d = IGNORE;
                                busy_d  = 1'b0;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_rise && ack_on_q && is_read_q) begin
                        tx_req_d = 1'b1;
                    end
                    if (scl_fall) begin
                        if (!ack_on_q) begin
                            sda_d_o  = 1'b0;
                            ack_on_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            ack_on_d = 1'b0;
                            cnt_d    = 3'd0;
                            if (is_read_q) begin
                                state_d = TX;
                                shift_d = tx_data_i;
                                sda_d_o = tx_data_i[7];
                            end else begin
                                state_d = RX;
                                sda_d_o = 1'b1;
                            end
                        end
                    end
                end
                RX: begin
                    if (scl_rise) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rx_data_d  = byte_in;
                            rx_valid_d = 1'b1;
                            state_d    = RX_ACK;
                        end
                    end
                end
                RX_ACK: begin
                    if (scl_fall) begin
                        if (!ack_on_q) begin
                            sda_d_o  = 1'b0;
                            ack_on_d = 1'b1;
                        end else begin
                            sda_d_o  = 1'b1;
                            ack_on_d = 1'b0;
                            state_d  = RX;
                        end
                    end
                end
                TX: begin
                    if (scl_rise) begin
                        cnt_d = cnt_q + 3'd1;
                    end else if (scl_fall) begin
                        // Counter has wrapped back to 0 once all eight bits were clocked out.
                        if (cnt_q == 3'd0) begin
                            sda_d_o  = 1'b1;
                            ack_on_d = 1'b0;
                            state_d  = TX_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            sda_d_o = shift_q[6];
                        end
                    end
                end
                TX_ACK: begin
                    if (scl_rise && !ack_on_q) begin
                        if (!sda_s) begin
                            tx_req_d = 1'b1;
                            ack_on_d = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end else if (scl_fall && ack_on_q) begin
                        ack_on_d = 1'b0;
                        cnt_d    = 3'd0;
                        shift_d  = tx_data_i;
                        sda_d_o  = tx_data_i[7];
                        state_d  = TX;
                    end
                end
                IDLE, IGNORE: begin
                    sda_d_o = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    sda_d_o = 1'b1;
                end
            endcase
        end
    end

    assign sda_o      = sda_q_o;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign tx_req_o   = tx_req_q;
    assign start_o    = start_q;
    assign stop_o     = stop_q;
    assign busy_o     = busy_q;

endmodule
